// File: rtl/regfile_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_if
// Purpose  : Bundles the reservation port, the two writeback request ports
//            and the register-file write port of regfile_wb_arbiter.
//            master = issue/writeback side, slave = arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_if #(
  parameter int XLEN = 32
);
  // Destination reservation from issue
  logic            rsv_valid;
  logic [4:0]      rsv_addr;
  logic            rsv_ready;
  logic [31:0]     busy_vec;

  // ALU writeback
  logic            req0_valid;
  logic            req0_ready;
  logic [4:0]      req0_addr;
  logic [XLEN-1:0] req0_data;

  // Load writeback
  logic            req1_valid;
  logic            req1_ready;
  logic [4:0]      req1_addr;
  logic [XLEN-1:0] req1_data;

  // Register file write port
  logic            wren;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic            err;

  modport master (
    output rsv_valid, rsv_addr,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  rsv_ready, busy_vec, req0_ready, req1_ready,
    input  wren, waddr, wdata, err
  );

  modport slave (
    input  rsv_valid, rsv_addr,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output rsv_ready, busy_vec, req0_ready, req1_ready,
    output wren, waddr, wdata, err
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register file's single write port between the ALU
//            (req0) and load (req1) writeback sources, and keeps a 2-bit
//            per-register pending-write scoreboard for RAW/WAW stalls.
//            Default arbitration: req1 priority with a starvation guard for
//            req0. Define ARB_RR_EN for 1-bit round-robin arbitration.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);

  logic            contest;
  logic            grant0;
  logic            grant1;
  logic            commit;
  logic [4:0]      commit_addr;
  logic [XLEN-1:0] commit_data;
  logic            rsv_full;
  logic            reserve;
  logic [1:0]      pend [32];

  assign contest = bus.req0_valid && bus.req1_valid;

`ifdef ARB_RR_EN
  // Port granted most recently: 0 = req0, 1 = req1
  logic last_port;

  // Round-robin: on contest the port not granted last wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      if (contest) begin
        grant0 = last_port;
        grant1 = !last_port;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  // Pointer follows every grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_port <= 1'b0;
    end else if (grant0) begin
      last_port <= 1'b0;
    end else if (grant1) begin
      last_port <= 1'b1;
    end
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;
  logic          starved;

  assign starved = (starve >= SW'(STARVE_MAX));

  // Fixed priority for req1 unless req0 has been denied STARVE_MAX times
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      if (contest) begin
        grant0 = starved;
        grant1 = !starved;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  // Count consecutive req0 denials; saturates once the guard is armed
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
    end else if (grant0 || !bus.req0_valid) begin
      starve <= '0;
    end else if (!starved) begin
      starve <= starve + 1'b1;
    end
  end
`endif

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Select the granted request; x0 targets are consumed without a write
  always_comb begin
    commit_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    commit_data = grant1 ? bus.req1_data : bus.req0_data;
    commit      = (grant0 || grant1) && (commit_addr != 5'd0);
  end

  // A full counter still accepts a reservation when the same register
  // retires in this cycle, since the pending count does not change.
  always_comb begin
    rsv_full      = (pend[bus.rsv_addr] == 2'd3) &&
                    !(commit && (commit_addr == bus.rsv_addr));
    bus.rsv_ready = rst && ((bus.rsv_addr == 5'd0) || !rsv_full);
    reserve       = bus.rsv_valid && bus.rsv_ready && (bus.rsv_addr != 5'd0);
  end

  // Registered write port to the register file plus sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wren  <= 1'b0;
      bus.waddr <= 5'd0;
      bus.wdata <= '0;
      bus.err   <= 1'b0;
    end else begin
      bus.wren <= commit;
      if (commit) begin
        bus.waddr <= commit_addr;
        bus.wdata <= commit_data;
      end
      if (commit && (pend[commit_addr] == 2'd0)) begin
        bus.err <= 1'b1;
      end
    end
  end

  // Pending-write counters; entry 0 is tied to zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (!rst || (i == 0)) begin
        pend[i] <= 2'd0;
      end else begin
        if (reserve && (bus.rsv_addr == 5'(i)) &&
            !(commit && (commit_addr == 5'(i)))) begin
          pend[i] <= pend[i] + 2'd1;
        end else if (commit && (commit_addr == 5'(i)) &&
                     !(reserve && (bus.rsv_addr == 5'(i))) &&
                     (pend[i] != 2'd0)) begin
          pend[i] <= pend[i] - 2'd1;
        end
      end
    end
  end

  // Busy flags straight from the counter flops
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      bus.busy_vec[i] = (pend[i] != 2'd0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed and randomized checks of regfile_wb_arbiter against a
//            behavioural model (integer pending counts, denial counter).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state
  int          pend [32];
  bit          m_err;
  bit          m_wren;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          denials;
  int          last_port;
  bit          g0, g1;
  logic        obs_r0, obs_r1, obs_rsv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check readies against the model, advance model, check outputs
  task automatic step();
    bit          c, res, rsv_ok, v0;
    logic [4:0]  ca, ra;
    logic [31:0] cd;
    logic [31:0] busy;
    #2;
    g0 = 0;
    g1 = 0;
    if (rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ARB_RR_EN
        g0 = (last_port == 1);
`else
        g0 = (denials >= STARVE_MAX);
`endif
        g1 = !g0;
      end else begin
        g0 = bus.req0_valid;
        g1 = bus.req1_valid;
      end
    end
    ca     = g1 ? bus.req1_addr : bus.req0_addr;
    cd     = g1 ? bus.req1_data : bus.req0_data;
    c      = (g0 || g1) && (ca != 0);
    ra     = bus.rsv_addr;
    v0     = bus.req0_valid;
    rsv_ok = rst && ((ra == 0) || (pend[ra] < 3) || (c && (ca == ra)));
    res    = bus.rsv_valid && rsv_ok && (ra != 0);
    obs_r0  = bus.req0_ready;
    obs_r1  = bus.req1_ready;
    obs_rsv = bus.rsv_ready;
    check("req0_ready", obs_r0, g0);
    check("req1_ready", obs_r1, g1);
    check("rsv_ready", obs_rsv, rsv_ok);
    @(posedge clk);
    #1;
    if (!rst) begin
      foreach (pend[i]) pend[i] = 0;
      m_err = 0; m_wren = 0; m_waddr = 0; m_wdata = 0;
      denials = 0; last_port = 0;
    end else begin
      m_wren = c;
      if (c) begin
        m_waddr = ca;
        m_wdata = cd;
        if (pend[ca] == 0) m_err = 1;
      end
      if (res) pend[ra]++;
      if (c && pend[ca] > 0) pend[ca]--;
      if (g0 || !v0) denials = 0; else denials++;
      if (g0) last_port = 0; else if (g1) last_port = 1;
    end
    for (int i = 0; i < 32; i++) busy[i] = (pend[i] > 0);
    check("wren", bus.wren, m_wren);
    check("waddr", bus.waddr, m_waddr);
    check("wdata", bus.wdata, m_wdata);
    check("busy_vec", bus.busy_vec, busy);
    check("err", bus.err, m_err);
  endtask

  task automatic idle();
    bus.rsv_valid  = 0;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
  endtask

  initial begin
    foreach (pend[i]) pend[i] = 0;
    m_err = 0; m_wren = 0; m_waddr = 0; m_wdata = 0; denials = 0; last_port = 0;

    // T1: reset with everything requesting
    rst = 0;
    bus.rsv_valid = 1;  bus.rsv_addr = 5'd1;
    bus.req0_valid = 1; bus.req0_addr = 5'd1; bus.req0_data = 32'h1;
    bus.req1_valid = 1; bus.req1_addr = 5'd2; bus.req1_data = 32'h2;
    repeat (3) begin
      step();
      check("t1_readies", {obs_r0, obs_r1, obs_rsv}, 3'b000);
      check("t1_wren", bus.wren, 1'b0);
      check("t1_busy", bus.busy_vec, 32'h0);
    end
    rst = 1;
    idle();
    step();

    // T2: reserve x5 then ALU write to x5
    bus.rsv_valid = 1; bus.rsv_addr = 5'd5;
    step();
    check("t2_busy_set", bus.busy_vec[5], 1'b1);
    bus.rsv_valid = 0;
    bus.req0_valid = 1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
    step();
    check("t2_grant", obs_r0, 1'b1);
    check("t2_write", {bus.wren, bus.waddr, bus.wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
    check("t2_busy_clr", bus.busy_vec[5], 1'b0);
    idle();
    step();
    check("t2_wren_pulse", bus.wren, 1'b0);

    // T3: continuous contest between x3 (ALU) and x4 (load)
    bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 32'h11;
    bus.req1_valid = 1; bus.req1_addr = 5'd4; bus.req1_data = 32'h22;
    for (int i = 0; i < 10; i++) begin
      step();
`ifdef ARB_RR_EN
      check("t3_pattern", obs_r1, (i % 2) == 0);
`else
      check("t3_pattern", obs_r1, (i % 5) != 4);
`endif
      if (g0) bus.req0_data = bus.req0_data + 1;
      if (g1) bus.req1_data = bus.req1_data + 1;
    end
    idle();
    rst = 0;
    step();
    rst = 1;

    // T4: saturation and simultaneous reserve+commit on x7
    bus.rsv_valid = 1; bus.rsv_addr = 5'd7;
    repeat (3) step();
    step();
    check("t4_rsv_full", obs_rsv, 1'b0);
    bus.req0_valid = 1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
    step();
    check("t4_rsv_with_commit", obs_rsv, 1'b1);
    bus.rsv_valid = 0;
    for (int i = 0; i < 3; i++) begin
      bus.req0_data = 32'h70 + i;
      step();
      check("t4_busy7", bus.busy_vec[7], i < 2);
    end
    check("t4_no_err", bus.err, 1'b0);
    idle();

    // T5: x0 request and commit with nothing pending
    bus.req1_valid = 1; bus.req1_addr = 5'd0; bus.req1_data = 32'h55;
    step();
    check("t5_x0_ready", obs_r1, 1'b1);
    check("t5_x0_nowrite", bus.wren, 1'b0);
    idle();
    bus.req0_valid = 1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
    step();
    check("t5_err_set", bus.err, 1'b1);
    idle();
    repeat (2) step();
    check("t5_err_sticky", bus.err, 1'b1);
    rst = 0;
    step();
    check("t5_err_clr", bus.err, 1'b0);
    rst = 1;

    // T6: reset while a load to x2 is pending and x2 count is 2
    bus.rsv_valid = 1; bus.rsv_addr = 5'd2;
    repeat (2) step();
    bus.rsv_valid = 0;
    bus.req1_valid = 1; bus.req1_addr = 5'd2; bus.req1_data = 32'hCAFE;
    rst = 0;
    step();
    check("t6_no_grant", obs_r1, 1'b0);
    check("t6_no_write", bus.wren, 1'b0);
    check("t6_busy_clr", bus.busy_vec, 32'h0);
    rst = 1;
    step();
    check("t6_grant_after", obs_r1, 1'b1);
    check("t6_write_after", {bus.wren, bus.waddr, bus.wdata}, {1'b1, 5'd2, 32'hCAFE});
    idle();
    step();

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      if (!(bus.req0_valid && !g0)) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_addr  = 5'($urandom_range(0, 7));
        bus.req0_data  = $urandom;
      end
      if (!(bus.req1_valid && !g1)) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_addr  = 5'($urandom_range(0, 7));
        bus.req1_data  = $urandom;
      end
      bus.rsv_valid = ($urandom_range(0, 1) != 0);
      bus.rsv_addr  = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 60) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
